// File: rtl/tone_gen_poly.sv
// Key-to-tone generator: up to 12 active-low keys select a chromatic semitone, played as a square wave.
// Optional TONE_SUSTAIN_EN macro keeps the last note sounding for SUSTAIN_CYC cycles after release.
module tone_gen_poly #(
   parameter int unsigned CLK_HZ      = 25000000,
   parameter int unsigned NUM_KEYS    = 3,
   parameter int unsigned CNT_W       = 18,
   parameter int unsigned SUSTAIN_CYC = 2500000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_n,
   input  logic [1:0]          octave,
   output logic                speaker,
   output logic                status,
   output logic [3:0]          note_idx,
   output logic [NUM_KEYS-1:0] led
);

   localparam int unsigned NOTE_W    = 4;
   localparam int unsigned NUM_NOTES = 12;

   // Octave-4 half-periods in clk cycles, C4 through B4
   localparam int unsigned BASE [NUM_NOTES] = '{
      CLK_HZ / 524, CLK_HZ / 554, CLK_HZ / 588, CLK_HZ / 622,
      CLK_HZ / 660, CLK_HZ / 698, CLK_HZ / 740, CLK_HZ / 784,
      CLK_HZ / 830, CLK_HZ / 880, CLK_HZ / 932, CLK_HZ / 988
   };

   if (NUM_KEYS < 1 || NUM_KEYS > NUM_NOTES || SUSTAIN_CYC < 1) begin : g_param_check
      $error("tone_gen_poly: NUM_KEYS must be 1..12 and SUSTAIN_CYC at least 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY    = 2'd1,
      SUSTAIN = 2'd2
   } state_e;

   function automatic logic [CNT_W-1:0] half_m1(input logic [NOTE_W-1:0] s, input logic [1:0] oct);
      int unsigned base;
      int unsigned half;
      base = (s < NOTE_W'(NUM_NOTES)) ? BASE[s] : BASE[0];
      case (oct)
         2'd0:    half = base << 1;
         2'd1:    half = base;
         2'd2:    half = base >> 1;
         default: half = base >> 2;
      endcase
      return CNT_W'(half - 32'd1);
   endfunction

   logic [NUM_KEYS-1:0] sync1_q, sync1_d;
   logic [NUM_KEYS-1:0] sync2_q, sync2_d;
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                spk_q, spk_d;
   logic                status_q, status_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [NUM_KEYS-1:0] ks;
   logic [NOTE_W-1:0]   sel;
   logic                any;

`ifdef TONE_SUSTAIN_EN
   localparam int unsigned SUS_W = $clog2(SUSTAIN_CYC + 1);
   logic [SUS_W-1:0] sus_q, sus_d;
`endif

   assign led = key_n;

   // Lowest-index pressed key wins
   always_comb begin
      ks  = ~sync2_q;
      any = |ks;
      sel = '0;
      for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
         if (ks[i]) sel = NOTE_W'(i);
      end
   end

   // Next-state and output logic; pitch only changes at a half-period boundary
   always_comb begin
      sync1_d  = key_n;
      sync2_d  = sync1_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      spk_d    = spk_q;
      status_d = status_q;
      note_d   = note_q;
`ifdef TONE_SUSTAIN_EN
      sus_d    = sus_q;
`endif
      case (state_q)
         IDLE: begin
            if (any) begin
               cnt_d    = half_m1(sel, octave);
               note_d   = sel;
               status_d = 1'b1;
               state_d  = PLAY;
            end
         end
         PLAY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (any) begin
               spk_d  = ~spk_q;
               cnt_d  = half_m1(sel, octave);
               note_d = sel;
            end else begin
`ifdef TONE_SUSTAIN_EN
               spk_d   = ~spk_q;
               cnt_d   = half_m1(note_q, octave);
               sus_d   = '0;
               state_d = SUSTAIN;
`else
               spk_d    = 1'b0;
               status_d = 1'b0;
               note_d   = '0;
               state_d  = IDLE;
`endif
            end
         end
`ifdef TONE_SUSTAIN_EN
         SUSTAIN: begin
            if (any) begin
               sus_d = '0;
            end else begin
               sus_d = sus_q + SUS_W'(1);
            end
            if (!any && sus_q == SUS_W'(SUSTAIN_CYC - 1)) begin
               spk_d    = 1'b0;
               status_d = 1'b0;
               note_d   = '0;
               cnt_d    = '0;
               sus_d    = '0;
               state_d  = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (any) begin
               spk_d   = ~spk_q;
               cnt_d   = half_m1(sel, octave);
               note_d  = sel;
               sus_d   = '0;
               state_d = PLAY;
            end else begin
               spk_d = ~spk_q;
               cnt_d = half_m1(note_q, octave);
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         state_q  <= IDLE;
         cnt_q    <= '0;
         spk_q    <= 1'b0;
         status_q <= 1'b0;
         note_q   <= '0;
`ifdef TONE_SUSTAIN_EN
         sus_q    <= '0;
`endif
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         spk_q    <= spk_d;
         status_q <= status_d;
         note_q   <= note_d;
`ifdef TONE_SUSTAIN_EN
         sus_q    <= sus_d;
`endif
      end
   end

   assign speaker  = spk_q;
   assign status   = status_q;
   assign note_idx = note_q;

endmodule
